// File: rtl/gpr_pkg.sv
// Shared widths, default queue depth and the queued long-result entry type.
package gpr_pkg;

  localparam int unsigned REG_W      = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NREG       = 32;
  localparam int unsigned QD_DEFAULT = 4;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] val;
  } wb_entry_t;

endpackage

// File: rtl/gpr_writeback_if.sv
// Writeback bus: ALU and long-result producers, issue/decode queries, regfile write port.
interface gpr_writeback_if;
  import gpr_pkg::*;

  logic              alu_v;
  logic [REG_W-1:0]  alu_rd;
  logic [DATA_W-1:0] alu_val;

  logic              lng_v;
  logic [REG_W-1:0]  lng_rd;
  logic [DATA_W-1:0] lng_val;
  logic              lng_rdy;

  logic              iss_v;
  logic [REG_W-1:0]  iss_rd;

  logic [REG_W-1:0]  q_rs;
  logic [REG_W-1:0]  q_rt;
  logic              stall;

  logic [REG_W-1:0]  rd;
  logic [DATA_W-1:0] rrd;
  logic              we;

  // Pipeline side driving results, issue and decode queries
  modport master (
    output alu_v, alu_rd, alu_val,
    output lng_v, lng_rd, lng_val,
    input  lng_rdy,
    output iss_v, iss_rd,
    output q_rs, q_rt,
    input  stall,
    input  rd, rrd, we
  );

  // Writeback block side
  modport slave (
    input  alu_v, alu_rd, alu_val,
    input  lng_v, lng_rd, lng_val,
    output lng_rdy,
    input  iss_v, iss_rd,
    input  q_rs, q_rt,
    output stall,
    output rd, rrd, we
  );

endinterface

// File: rtl/wb_fifo.sv
// Small circular FIFO for long results; pointers wrap naturally (power-of-two depth).
module wb_fifo
  import gpr_pkg::*;
#(
  parameter int unsigned Depth = QD_DEFAULT,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t wdata,
  input  logic      pop,
  output wb_entry_t rdata,
  output logic      full,
  output logic      empty
);

  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(Depth);

  wb_entry_t         mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == FullCnt);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care once pointers reset
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/gpr_writeback.sv
// GPR writeback arbiter: ALU results win, long results drain from a FIFO, busy scoreboard.
module gpr_writeback
  import gpr_pkg::*;
#(
  parameter int unsigned QD = QD_DEFAULT
) (
  input logic            clk,
  input logic            rst,
  gpr_writeback_if.slave wb
);

  logic              alu_wr;
  logic              push, pop, lng_wr;
  logic              full, empty;
  wb_entry_t         head, lng_in;

  logic              we_q, we_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic [DATA_W-1:0] rrd_q, rrd_d;
  logic [NREG-1:0]   busy_q, busy_d;

  // Writes to $0 never reach the register file
  assign alu_wr = wb.alu_v && (wb.alu_rd != '0);
  assign push   = wb.lng_v && !full;
  assign pop    = !alu_wr && !empty;
  assign lng_wr = pop && (head.rd != '0);

  assign lng_in.rd  = wb.lng_rd;
  assign lng_in.val = wb.lng_val;

  wb_fifo #(
    .Depth (QD)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (lng_in),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Select the write for next cycle; rd/rrd hold when nothing is written
  always_comb begin
    we_d  = alu_wr || lng_wr;
    rd_d  = rd_q;
    rrd_d = rrd_q;
    if (alu_wr) begin
      rd_d  = wb.alu_rd;
      rrd_d = wb.alu_val;
    end else if (lng_wr) begin
      rd_d  = head.rd;
      rrd_d = head.val;
    end
  end

  // Scoreboard update: clear on pop, then set on issue so a same-cycle set wins
  always_comb begin
    busy_d = busy_q;
    if (pop) busy_d[head.rd] = 1'b0;
    if (wb.iss_v && (wb.iss_rd != '0)) busy_d[wb.iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Output and scoreboard registers
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= 1'b0;
      rd_q   <= '0;
      rrd_q  <= '0;
      busy_q <= '0;
    end else begin
      we_q   <= we_d;
      rd_q   <= rd_d;
      rrd_q  <= rrd_d;
      busy_q <= busy_d;
    end
  end

  assign wb.we      = we_q;
  assign wb.rd      = rd_q;
  assign wb.rrd     = rrd_q;
  assign wb.lng_rdy = !full;
  assign wb.stall   = busy_q[wb.q_rs] | busy_q[wb.q_rt];

endmodule

// File: doc/gpr_writeback.md
GPR_WRITEBACK -- requirements
Module: gpr_writeback

Interface
REQ-001 The block SHALL have parameter QD, default 4, meaning long-result queue depth in entries (power of two, at least 2).
REQ-002 The block SHALL have port clk, input, 1 bit: sole clock, all state updates on posedge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port alu_v, input, 1 bit: single-cycle result valid, with no backpressure.
REQ-005 The block SHALL have ports alu_rd, input, 5 bits, and alu_val, input, 32 bits: ALU destination register and value.
REQ-006 The block SHALL have port lng_v, input, 1 bit: multi-cycle (mul/div/load) result valid.
REQ-007 The block SHALL have ports lng_rd, input, 5 bits, and lng_val, input, 32 bits: long-result destination and value.
REQ-008 The block SHALL have port lng_rdy, output, 1 bit: queue can accept; a transfer occurs when lng_v and lng_rdy are both high.
REQ-009 The block SHALL have ports iss_v, input, 1 bit, and iss_rd, input, 5 bits: a long op issued to that destination.
REQ-010 The block SHALL have ports q_rs and q_rt, input, 5 bits each: registers the decoder is about to read.
REQ-011 The block SHALL have port stall, output, 1 bit: q_rs or q_rt is busy.
REQ-012 The block SHALL have ports rd, output, 5 bits; rrd, output, 32 bits; we, output, 1 bit: the register-file write port.

Function
REQ-013 rd, rrd and we SHALL be registered: an accepted result presented in cycle N drives we in cycle N+1 at the earliest.
REQ-014 ALU results SHALL have absolute priority: alu_v with alu_rd!=0 in cycle N SHALL produce we=1, rd=alu_rd, rrd=alu_val in cycle N+1.
REQ-015 Long results SHALL enter a QD-entry FIFO; lng_rdy SHALL be high exactly when the FIFO is not full, combinational from FIFO state only.
REQ-016 In any cycle without a qualifying ALU write, a non-empty FIFO SHALL pop its head and write it in the next cycle.
REQ-017 Simultaneous push and pop SHALL be legal at any occupancy, including full (pop frees the slot but lng_rdy stays low that cycle), and pointers SHALL wrap modulo QD.
REQ-018 we SHALL never be asserted with rd==0: ALU results to $0 SHALL be dropped; long results to $0 SHALL be accepted into the FIFO and discarded at pop without a write.
REQ-019 When no write is issued, we SHALL be 0, and rd and rrd SHALL hold their previous values.
REQ-020 A 32-bit busy scoreboard SHALL set bit iss_rd on iss_v (iss_rd!=0), effective from the next cycle.
REQ-021 The busy bit for rd SHALL clear in the cycle after the long result is written (or discarded) at pop.
REQ-022 If a set and a clear hit the same bit in the same cycle, the set SHALL win.
REQ-023 stall SHALL be combinational: busy[q_rs] | busy[q_rt]; busy[0] SHALL always read 0.
REQ-024 ALU writes SHALL NOT modify the scoreboard; issue logic guarantees no ALU write targets a busy register.

Reset
REQ-025 While rst is high, we, rd, rrd, all busy bits, FIFO pointers and count SHALL be 0, lng_rdy SHALL be 1, and stall SHALL be 0.
REQ-026 Reset asserted mid-operation SHALL discard all queued results and pending busy bits with no further writes; inputs in that cycle SHALL be ignored.

Structure
REQ-027 The shared package gpr_pkg SHALL hold REG_W=5, DATA_W=32, NREG=32 and the QD default.
REQ-028 The FIFO SHALL be a sub-module, wb_fifo (push/pop/full/empty, pointers plus count), instantiated once.

Verification
REQ-029 Scenario: alu_v=1, alu_rd=5, alu_val=0xDEADBEEF -> next cycle we=1, rd=5, rrd=0xDEADBEEF.
REQ-030 Scenario: alu_v every cycle for 6 cycles while lng pushes 4 results -> lng_rdy falls after the 4th push and no long write appears until alu_v drops; the queued results are then written in FIFO order over the following 4 cycles.
REQ-031 Scenario: iss_v with iss_rd=9, then q_rs=9 -> stall=1 until the cycle after the lng result to r9 is written, then stall=0.
REQ-032 Scenario: alu_rd=0 and lng_rd=0 results -> we never asserted; the FIFO slot is freed; iss_rd=0 never causes stall.
REQ-033 Scenario: iss_v to r7 in the same cycle as a pop of a pending r7 result -> busy[7] remains 1.
REQ-034 Scenario: FIFO holds 3 entries and busy bits are set, then rst is high for 1 cycle -> no writes, stall=0, lng_rdy=1, and a subsequent push writes normally.
